// File: rtl/abc_pattern_pkg.sv
// abc_pattern_pkg
//   Shared types and constants for the (a,b,c) condition-bus pattern encoder:
//   symbol and FSM state enums, the pattern for each symbol, and the decoder
//   response the loopback checker expects for a given symbol/decoder pair.
package abc_pattern_pkg;

  typedef enum logic [1:0] {
    SYM_IDLE      = 2'd0,
    SYM_MATCH_BHI = 2'd1,
    SYM_MATCH_BLO = 2'd2,
    SYM_NEAR_MISS = 2'd3
  } sym_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  typedef struct packed {
    logic [2:0] a;
    logic       b;
    logic [1:0] c;
  } pat_t;

  localparam pat_t PAT_IDLE      = '{a: 3'd0, b: 1'b0, c: 2'd0};
  localparam pat_t PAT_MATCH_BHI = '{a: 3'd2, b: 1'b1, c: 2'd0};
  localparam pat_t PAT_MATCH_BLO = '{a: 3'd2, b: 1'b0, c: 2'd0};
  localparam pat_t PAT_NEAR_MISS = '{a: 3'd2, b: 1'b1, c: 2'd1};

  function automatic pat_t sym_pattern(input sym_e s);
    pat_t p;
    case (s)
      SYM_MATCH_BHI: p = PAT_MATCH_BHI;
      SYM_MATCH_BLO: p = PAT_MATCH_BLO;
      SYM_NEAR_MISS: p = PAT_NEAR_MISS;
      default:       p = PAT_IDLE;
    endcase
    return p;
  endfunction

  // dec_sel = 0 selects the b-high detector, 1 the b-low detector.
  function automatic logic expected_y(input sym_e s, input logic dec_sel);
    return ((s == SYM_MATCH_BHI) && !dec_sel) || ((s == SYM_MATCH_BLO) && dec_sel);
  endfunction

endpackage

// File: rtl/abc_loopback_checker.sv
// abc_loopback_checker
//   Compares the decoder response against the expected value at each sample
//   point; keeps a sticky error flag and a saturating mismatch count.
//   Ports:
//     clk, rst_n     clock, async active-low reset
//     sample_en      compare y_in against y_exp this cycle
//     y_in, y_exp    observed / expected decoder response
//     err            sticky mismatch flag (cleared only by reset)
//     mismatch_cnt   mismatch count, saturates at 255
module abc_loopback_checker (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_en,
  input  logic       y_in,
  input  logic       y_exp,
  output logic       err,
  output logic [7:0] mismatch_cnt
);

  logic       err_q, err_d;
  logic [7:0] cnt_q, cnt_d;
  logic       miss;

  always_comb begin
    miss  = sample_en && (y_in != y_exp);
    err_d = err_q | miss;
    cnt_d = cnt_q;
    if (miss && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
      cnt_q <= 8'd0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign err          = err_q;
  assign mismatch_cnt = cnt_q;

endmodule

// File: rtl/abc_pattern_encoder.sv
// abc_pattern_encoder
//   Accepts a symbol over valid/ready and drives its (a,b,c) pattern for
//   HOLD_CYCLES cycles, followed by a one-cycle idle gap, repeated rep+1 times.
//   Optional loopback check of the decoder response when ABC_LOOPBACK_CHECK_EN
//   is defined; otherwise err/mismatch_cnt are tied low and y_in/dec_sel unused.
//   Ports:
//     clk, rst_n               clock, async active-low reset
//     sym_valid / sym_ready    symbol handshake (ready only in IDLE)
//     sym, rep, dec_sel        symbol, repetitions-1, decoder variant
//     y_in                     decoder response
//     a, b, c, pat_valid       registered pattern bus
//     busy, done               FSM not idle / one-cycle completion pulse
//     err, mismatch_cnt        loopback results
//
//   state    | meaning
//   ST_IDLE  | bus idle, ready for a symbol
//   ST_DRIVE | latched pattern on the bus, hold counter running
//   ST_GAP   | one idle cycle between repetitions
module abc_pattern_encoder
  import abc_pattern_pkg::*;
#(
  parameter int HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sym_valid,
  output logic       sym_ready,
  input  logic [1:0] sym,
  input  logic [2:0] rep,
  input  logic       dec_sel,
  input  logic       y_in,
  output logic [2:0] a,
  output logic       b,
  output logic [1:0] c,
  output logic       pat_valid,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] mismatch_cnt
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [2:0]        rep_cnt_q, rep_cnt_d;
  sym_e              sym_q, sym_d;
  logic              dec_sel_q, dec_sel_d;
  pat_t              pat_q, pat_d;
  logic              pat_valid_q, pat_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Outputs are registered, so each branch computes the bus value for the
  // state being entered rather than the state being left.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    sym_d       = sym_q;
    dec_sel_d   = dec_sel_q;
    pat_d       = pat_q;
    pat_valid_d = pat_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sym_valid) begin
          sym_d       = sym_e'(sym);
          rep_cnt_d   = rep;
          dec_sel_d   = dec_sel;
          hold_cnt_d  = HOLD_LOAD;
          pat_d       = sym_pattern(sym_e'(sym));
          pat_valid_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (hold_cnt_q == '0) begin
          pat_d       = PAT_IDLE;
          pat_valid_d = 1'b0;
          state_d     = ST_GAP;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      ST_GAP: begin
        if (rep_cnt_q != 3'd0) begin
          rep_cnt_d   = rep_cnt_q - 3'd1;
          hold_cnt_d  = HOLD_LOAD;
          pat_d       = sym_pattern(sym_q);
          pat_valid_d = 1'b1;
          state_d     = ST_DRIVE;
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        pat_d       = PAT_IDLE;
        pat_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_cnt_q  <= '0;
      rep_cnt_q   <= 3'd0;
      sym_q       <= SYM_IDLE;
      dec_sel_q   <= 1'b0;
      pat_q       <= PAT_IDLE;
      pat_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      sym_q       <= sym_d;
      dec_sel_q   <= dec_sel_d;
      pat_q       <= pat_d;
      pat_valid_q <= pat_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign sym_ready = (state_q == ST_IDLE);
  assign a         = pat_q.a;
  assign b         = pat_q.b;
  assign c         = pat_q.c;
  assign pat_valid = pat_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef ABC_LOOPBACK_CHECK_EN
  // Last DRIVE cycle: the pattern has been stable for HOLD_CYCLES-1 cycles,
  // giving the combinational decoder time to settle.
  logic sample_en;
  assign sample_en = (state_q == ST_DRIVE) && (hold_cnt_q == '0);

  abc_loopback_checker u_checker (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_en    (sample_en),
    .y_in         (y_in),
    .y_exp        (expected_y(sym_q, dec_sel_q)),
    .err          (err),
    .mismatch_cnt (mismatch_cnt)
  );
`else
  logic unused_loopback;
  assign unused_loopback = ^{y_in, dec_sel_q};
  assign err             = 1'b0;
  assign mismatch_cnt    = 8'd0;
`endif

endmodule

// File: tb/tb_abc_pattern_encoder.sv
module tb_abc_pattern_encoder;

  localparam int H = 2;
`ifdef ABC_LOOPBACK_CHECK_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       sym_valid;
  logic       sym_ready;
  logic [1:0] sym;
  logic [2:0] rep;
  logic       dec_sel;
  logic       y_in;
  logic [2:0] a;
  logic       b;
  logic [1:0] c;
  logic       pat_valid;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] mismatch_cnt;
  logic       model_blo;

  int n_assert = 0;
  int n_fail   = 0;

  abc_pattern_encoder #(.HOLD_CYCLES(H)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sym_valid    (sym_valid),
    .sym_ready    (sym_ready),
    .sym          (sym),
    .rep          (rep),
    .dec_sel      (dec_sel),
    .y_in         (y_in),
    .a            (a),
    .b            (b),
    .c            (c),
    .pat_valid    (pat_valid),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .mismatch_cnt (mismatch_cnt)
  );

  // Decoder model: b-low detector matches (2,0,0), b-high detector (2,1,0).
  assign y_in = (a == 3'd2) && (c == 2'd0) && (b == !model_blo);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bus_word(input logic [2:0] ea, input logic eb, input logic [1:0] ec,
                                           input logic pv, input logic bz, input logic dn);
    return 32'({ea, eb, ec, pv, bz, dn});
  endfunction

  function automatic logic [31:0] bus_obs();
    return 32'({a, b, c, pat_valid, busy, done});
  endfunction

  // Called in the first DRIVE cycle; returns in the done cycle.
  task automatic expect_symbol(input string tag, input logic [2:0] ea, input logic eb,
                               input logic [1:0] ec, input int r);
    for (int k = 0; k <= r; k++) begin
      for (int h = 0; h < H; h++) begin
        chk($sformatf("%s drive r%0d h%0d", tag, k, h), bus_obs(), bus_word(ea, eb, ec, 1'b1, 1'b1, 1'b0));
        chk($sformatf("%s ready r%0d h%0d", tag, k, h), 32'(sym_ready), 32'd0);
        tick();
      end
      chk($sformatf("%s gap r%0d", tag, k), bus_obs(), bus_word(3'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0));
      tick();
    end
    chk($sformatf("%s done", tag), bus_obs(), bus_word(3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1));
    chk($sformatf("%s ready at done", tag), 32'(sym_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    sym_valid = 1'b0;
    sym       = 2'd0;
    rep       = 3'd0;
    dec_sel   = 1'b0;
    model_blo = 1'b0;
    #12;
    chk("reset bus", bus_obs(), 32'd0);
    chk("reset ready", 32'(sym_ready), 32'd1);
    chk("reset err", 32'(err), 32'd0);
    chk("reset mcnt", 32'(mismatch_cnt), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle bus", bus_obs(), 32'd0);

    // Single MATCH_BHI, one repetition
    sym_valid = 1'b1; sym = 2'd1; rep = 3'd0; dec_sel = 1'b0; model_blo = 1'b0;
    tick();
    sym_valid = 1'b0;
    expect_symbol("bhi", 3'd2, 1'b1, 2'd0, 0);
    tick();
    chk("bhi after done", bus_obs(), 32'd0);
    chk("bhi err", 32'(err), 32'd0);

    // NEAR_MISS, three repetitions: done lands on cycle 10
    sym_valid = 1'b1; sym = 2'd3; rep = 3'd2;
    tick();
    sym_valid = 1'b0;
    expect_symbol("near", 3'd2, 1'b1, 2'd1, 2);
    tick();

    // Symbol 0 still runs DRIVE/GAP with pat_valid high
    sym_valid = 1'b1; sym = 2'd0; rep = 3'd0;
    tick();
    sym_valid = 1'b0;
    expect_symbol("idle sym", 3'd0, 1'b0, 2'd0, 0);
    tick();

    // Back-to-back: second request held during busy, taken in the done cycle
    sym_valid = 1'b1; sym = 2'd1; rep = 3'd1; dec_sel = 1'b0;
    tick();
    sym = 2'd2; rep = 3'd0; dec_sel = 1'b1;
    expect_symbol("b2b first", 3'd2, 1'b1, 2'd0, 1);
    model_blo = 1'b1;
    tick();
    sym_valid = 1'b0;
    expect_symbol("b2b blo", 3'd2, 1'b0, 2'd0, 0);
    chk("match err", 32'(err), 32'd0);
    chk("match mcnt", 32'(mismatch_cnt), 32'd0);
    tick();

    // Wrong decoder: every MATCH_BHI sample mismatches the b-low model
    dec_sel = 1'b0; model_blo = 1'b1; sym = 2'd1; rep = 3'd0;
    for (int i = 0; i < 300; i++) begin
      sym_valid = 1'b1;
      tick();
      sym_valid = 1'b0;
      tick();
      tick();
      tick();
      chk($sformatf("wrong done i%0d", i), 32'(done), 32'd1);
      chk($sformatf("wrong err i%0d", i), 32'(err), LB ? 32'd1 : 32'd0);
      chk($sformatf("wrong mcnt i%0d", i), 32'(mismatch_cnt),
          LB ? ((i + 1 > 255) ? 32'd255 : 32'(i + 1)) : 32'd0);
    end
    tick();

    // Reset in the middle of DRIVE
    sym_valid = 1'b1; sym = 2'd3; rep = 3'd3;
    tick();
    sym_valid = 1'b0;
    tick();
    chk("pre-reset drive", bus_obs(), bus_word(3'd2, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset bus", bus_obs(), 32'd0);
    chk("async reset ready", 32'(sym_ready), 32'd1);
    chk("async reset err", 32'(err), 32'd0);
    chk("async reset mcnt", 32'(mismatch_cnt), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("post-reset idle c%0d", i), bus_obs(), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
